pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 3, balls per game (1..15).
REQ-002 SHALL have parameter SCORE_W, default 8, score counter width.
REQ-003 SHALL have parameter WAIT_FRAMES, default 120, frame_ticks spent in NEWBALL/OVER (0..255).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port btn1  input  2  player-1 buttons, synchronised upstream.
REQ-007 SHALL have port btn2  input  2  player-2 buttons, synchronised upstream.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port hit  input  1  one-cycle pulse, ball struck paddle.
REQ-010 SHALL have port miss  input  1  one-cycle pulse, ball passed paddle.
REQ-011 SHALL have port state  output  2  current game state.
REQ-012 SHALL have port gra_still  output  1  freeze graphics; high in all states except PLAY.
REQ-013 SHALL have port balls_left  output  4  balls remaining after the one in play.
REQ-014 SHALL have port score  output  SCORE_W  current game score.
REQ-015 SHALL have port hiscore  output  SCORE_W  best score since reset (see Configuration).

Function
REQ-016 SHALL implement states NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3; all outputs registered.
REQ-017 NEWGAME: when (btn1|btn2)!=0 SHALL go to PLAY next cycle, set balls_left=NUM_BALLS-1, clear score.
REQ-018 PLAY: hit SHALL increment score by 1, saturating at 2^SCORE_W-1.
REQ-019 PLAY: miss with balls_left>0 SHALL decrement balls_left, load timer with WAIT_FRAMES, go to NEWBALL.
REQ-020 PLAY: miss with balls_left==0 SHALL load timer with WAIT_FRAMES and go to OVER.
REQ-021 hit and miss in the same PLAY cycle SHALL both take effect (score increments and miss transition occurs).
REQ-022 NEWBALL/OVER: timer SHALL decrement on each frame_tick; on the cycle timer==0, NEWBALL SHALL go to PLAY, OVER to NEWGAME.
REQ-023 WAIT_FRAMES=0 SHALL leave NEWBALL/OVER on the cycle after entry.
REQ-024 Buttons SHALL be ignored outside NEWGAME; hit/miss SHALL be ignored outside PLAY.
REQ-025 On OVER->NEWGAME, balls_left SHALL reload to NUM_BALLS; score SHALL hold until the next game start.

Reset
REQ-026 reset SHALL override all other inputs in the same cycle, including mid-game and mid-timer.
REQ-027 After reset: state=NEWGAME, gra_still=1, balls_left=NUM_BALLS, score=0, hiscore=0, timer=0.

Configuration
REQ-028 Macro PONG_HISCORE_EN defined: on entry to OVER, if score>hiscore then hiscore<=score; hiscore cleared only by reset.
REQ-029 Macro PONG_HISCORE_EN undefined: hiscore SHALL be tied to 0 and no hiscore register synthesised.

Structure
REQ-030 State encoding localparams and default WAIT_FRAMES SHALL live in shared package pong_pkg.
REQ-031 Frame timer SHALL be sub-module pong_frame_timer (load, frame_tick, done; 8-bit down-counter).

Verification (NUM_BALLS=3, WAIT_FRAMES=4, SCORE_W=8)
REQ-032 reset, btn1=2'b01 one cycle -> state=PLAY next cycle, balls_left=2, score=0, gra_still=0.
REQ-033 in PLAY, 5 hit pulses then miss -> score=5, state=NEWBALL, balls_left=1; after 4 frame_ticks state=PLAY.
REQ-034 three misses with balls_left 2,1,0 -> third miss gives OVER; 4 frame_ticks later NEWGAME, balls_left=3.
REQ-035 SCORE_W=3, 9 hits -> score saturates at 7; hit and miss same cycle -> score+1 and NEWBALL.
REQ-036 PONG_HISCORE_EN: games scoring 6 then 4 -> hiscore=6 after both; reset -> hiscore=0; macro off -> hiscore always 0.
REQ-037 reset asserted in NEWBALL with timer=2 -> next cycle NEWGAME, all REQ-027 values; buttons in OVER ignored.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding and timer defaults.
package pong_pkg;

  localparam logic [1:0] ST_NEWGAME = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_NEWBALL = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  typedef enum logic [1:0] {
    NEWGAME = ST_NEWGAME,
    PLAY    = ST_PLAY,
    NEWBALL = ST_NEWBALL,
    OVER    = ST_OVER
  } state_t;

  localparam int unsigned WAIT_FRAMES_DEFAULT = 120;
  localparam int unsigned TIMER_W             = 8;
  localparam int unsigned BALLS_W             = 4;

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-count down-timer: load presets WAIT_FRAMES, each frame_tick counts toward zero.
module pong_frame_timer
  import pong_pkg::*;
#(
  parameter int unsigned WAIT_FRAMES = WAIT_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic frame_tick,
  output logic done
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Load wins over tick; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TIMER_W'(WAIT_FRAMES);
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game flow FSM: game start, scoring, ball count and wait periods.
// Define PONG_HISCORE_EN to keep a best-score register; otherwise hiscore reads 0.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = 3,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned WAIT_FRAMES = WAIT_FRAMES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         btn1,
  input  logic [1:0]         btn2,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               miss,
  output logic [1:0]         state,
  output logic               gra_still,
  output logic [BALLS_W-1:0] balls_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic               gra_still_q, gra_still_d;
  logic [BALLS_W-1:0] balls_q, balls_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               timer_load;
  logic               timer_done;
`ifdef PONG_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
`endif

  pong_frame_timer #(
    .WAIT_FRAMES (WAIT_FRAMES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .frame_tick (frame_tick),
    .done       (timer_done)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    balls_d    = balls_q;
    score_d    = score_q;
    timer_load = 1'b0;
`ifdef PONG_HISCORE_EN
    hiscore_d  = hiscore_q;
`endif
    case (state_q)
      NEWGAME: begin
        if ((btn1 | btn2) != 2'b00) begin
          state_d = PLAY;
          balls_d = BALLS_W'(NUM_BALLS - 1);
          score_d = '0;
        end
      end
      PLAY: begin
        if (hit && (score_q != SCORE_MAX)) begin
          score_d = score_q + SCORE_W'(1);
        end
        if (miss) begin
          timer_load = 1'b1;
          if (balls_q != '0) begin
            balls_d = balls_q - BALLS_W'(1);
            state_d = NEWBALL;
          end else begin
            state_d = OVER;
`ifdef PONG_HISCORE_EN
            if (score_d > hiscore_q) begin
              hiscore_d = score_d;
            end
`endif
          end
        end
      end
      NEWBALL: begin
        if (timer_done) begin
          state_d = PLAY;
        end
      end
      OVER: begin
        if (timer_done) begin
          state_d = NEWGAME;
          balls_d = BALLS_W'(NUM_BALLS);
        end
      end
      default: state_d = NEWGAME;
    endcase
    gra_still_d = (state_d != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NEWGAME;
      gra_still_q <= 1'b1;
      balls_q     <= BALLS_W'(NUM_BALLS);
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      gra_still_q <= gra_still_d;
      balls_q     <= balls_d;
      score_q     <= score_d;
    end
  end

`ifdef PONG_HISCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore_q <= '0;
    end else begin
      hiscore_q <= hiscore_d;
    end
  end
  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign state      = state_q;
  assign gra_still  = gra_still_q;
  assign balls_left = balls_q;
  assign score      = score_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: dut_a (WAIT_FRAMES=4, SCORE_W=8), dut_b (WAIT_FRAMES=0, SCORE_W=3).
module tb_pong_game_ctrl;

`ifdef PONG_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         sel_b;
    logic [1:0] st;
    logic       gra;
    logic [3:0] balls;
    logic [7:0] score;
    logic [7:0] hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn1_a = '0, btn2_a = '0, btn1_b = '0, btn2_b = '0;
  logic       tick_a = 1'b0, hit_a = 1'b0, miss_a = 1'b0;
  logic       tick_b = 1'b0, hit_b = 1'b0, miss_b = 1'b0;

  logic [1:0] state_a, state_b;
  logic       gra_a, gra_b;
  logic [3:0] balls_a, balls_b;
  logic [7:0] score_a, hi_a;
  logic [2:0] score_b, hi_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.NUM_BALLS(3), .SCORE_W(8), .WAIT_FRAMES(4)) dut_a (
    .clk(clk), .reset(reset), .btn1(btn1_a), .btn2(btn2_a), .frame_tick(tick_a),
    .hit(hit_a), .miss(miss_a), .state(state_a), .gra_still(gra_a),
    .balls_left(balls_a), .score(score_a), .hiscore(hi_a)
  );

  pong_game_ctrl #(.NUM_BALLS(3), .SCORE_W(3), .WAIT_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .btn1(btn1_b), .btn2(btn2_b), .frame_tick(tick_b),
    .hit(hit_b), .miss(miss_b), .state(state_b), .gra_still(gra_b),
    .balls_left(balls_b), .score(score_b), .hiscore(hi_b)
  );

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [1:0] st;
      logic       g;
      logic [3:0] b;
      logic [7:0] s, h;
      e = sb.pop_front();
      if (e.sel_b) begin
        st = state_b; g = gra_b; b = balls_b; s = 8'(score_b); h = 8'(hi_b);
      end else begin
        st = state_a; g = gra_a; b = balls_a; s = score_a; h = hi_a;
      end
      checks++;
      if (st !== e.st || g !== e.gra || b !== e.balls || s !== e.score || h !== e.hi) begin
        errors++;
        $display("FAIL %s: got state=%0d gra=%0d balls=%0d score=%0d hi=%0d, want state=%0d gra=%0d balls=%0d score=%0d hi=%0d",
                 e.name, st, g, b, s, h, e.st, e.gra, e.balls, e.score, e.hi);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string n, input bit sel_b, input logic [1:0] st,
                           input logic [3:0] b, input logic [7:0] s, input logic [7:0] hi_on);
    exp_t e;
    e.name  = n;
    e.sel_b = sel_b;
    e.st    = st;
    e.gra   = (st != 2'd1);
    e.balls = b;
    e.score = s;
    e.hi    = HI_EN ? hi_on : 8'd0;
    sb.push_back(e);
  endtask

  task automatic hits_a(input int n);
    hit_a = 1'b1; repeat (n) step(); hit_a = 1'b0;
  endtask

  task automatic pulse_miss_a();
    miss_a = 1'b1; step(); miss_a = 1'b0;
  endtask

  // Each tick is a pulse followed by one idle cycle.
  task automatic ticks_a(input int n);
    repeat (n) begin
      tick_a = 1'b1; step(); tick_a = 1'b0; step();
    end
  endtask

  task automatic start_a(input logic [1:0] b1, input logic [1:0] b2);
    btn1_a = b1; btn2_a = b2; step(); btn1_a = '0; btn2_a = '0;
  endtask

  initial begin
    // Reset overrides simultaneous buttons, hit and frame_tick.
    reset = 1'b1; btn1_a = 2'b01; hit_a = 1'b1; tick_a = 1'b1; btn1_b = 2'b10;
    step();
    reset = 1'b0; btn1_a = '0; hit_a = 1'b0; tick_a = 1'b0; btn1_b = '0;
    expect_st("reset_a", 0, 2'd0, 4'd3, 8'd0, 8'd0);
    expect_st("reset_b", 1, 2'd0, 4'd3, 8'd0, 8'd0);

    // Game 1: score 5
    start_a(2'b01, 2'b00);           expect_st("g1_start", 0, 2'd1, 4'd2, 8'd0, 8'd0);
    hits_a(5);                       expect_st("g1_hits5", 0, 2'd1, 4'd2, 8'd5, 8'd0);
    start_a(2'b00, 2'b11);           expect_st("btn_in_play", 0, 2'd1, 4'd2, 8'd5, 8'd0);
    pulse_miss_a();                  expect_st("g1_miss1", 0, 2'd2, 4'd1, 8'd5, 8'd0);
    hits_a(1);                       expect_st("hit_in_newball", 0, 2'd2, 4'd1, 8'd5, 8'd0);
    ticks_a(3);                      expect_st("nb_after3", 0, 2'd2, 4'd1, 8'd5, 8'd0);
    ticks_a(1);                      expect_st("nb_after4", 0, 2'd1, 4'd1, 8'd5, 8'd0);
    pulse_miss_a();                  expect_st("g1_miss2", 0, 2'd2, 4'd0, 8'd5, 8'd0);
    ticks_a(4);                      expect_st("g1_play3", 0, 2'd1, 4'd0, 8'd5, 8'd0);
    pulse_miss_a();                  expect_st("g1_over", 0, 2'd3, 4'd0, 8'd5, 8'd5);
    start_a(2'b11, 2'b00);           expect_st("btn_in_over", 0, 2'd3, 4'd0, 8'd5, 8'd5);
    ticks_a(3);                      expect_st("over_after3", 0, 2'd3, 4'd0, 8'd5, 8'd5);
    ticks_a(1);                      expect_st("g1_newgame", 0, 2'd0, 4'd3, 8'd5, 8'd5);

    // Game 2: score 6
    start_a(2'b00, 2'b10);           expect_st("g2_start", 0, 2'd1, 4'd2, 8'd0, 8'd5);
    hits_a(6);                       expect_st("g2_hits6", 0, 2'd1, 4'd2, 8'd6, 8'd5);
    pulse_miss_a(); ticks_a(4);
    pulse_miss_a(); ticks_a(4);      expect_st("g2_last_ball", 0, 2'd1, 4'd0, 8'd6, 8'd5);
    pulse_miss_a();                  expect_st("g2_over", 0, 2'd3, 4'd0, 8'd6, 8'd6);
    ticks_a(4);                      expect_st("g2_newgame", 0, 2'd0, 4'd3, 8'd6, 8'd6);

    // Game 3: score 4, hiscore keeps 6
    start_a(2'b10, 2'b00);           expect_st("g3_start", 0, 2'd1, 4'd2, 8'd0, 8'd6);
    hits_a(4);
    pulse_miss_a(); ticks_a(4);
    pulse_miss_a(); ticks_a(4);
    pulse_miss_a();                  expect_st("g3_over", 0, 2'd3, 4'd0, 8'd4, 8'd6);
    ticks_a(4);                      expect_st("g3_newgame", 0, 2'd0, 4'd3, 8'd4, 8'd6);

    // Reset in NEWBALL with two frames left
    start_a(2'b01, 2'b00);           expect_st("g4_start", 0, 2'd1, 4'd2, 8'd0, 8'd6);
    pulse_miss_a(); ticks_a(2);      expect_st("g4_nb_t2", 0, 2'd2, 4'd1, 8'd0, 8'd6);
    reset = 1'b1; step(); reset = 1'b0;
    expect_st("reset_mid_timer", 0, 2'd0, 4'd3, 8'd0, 8'd0);
    start_a(2'b01, 2'b00); pulse_miss_a();
    ticks_a(3);                      expect_st("timer_reload", 0, 2'd2, 4'd1, 8'd0, 8'd0);

    // dut_b: zero wait frames, 3-bit score saturation, hit+miss together
    btn1_b = 2'b01; step(); btn1_b = '0;
    expect_st("b_start", 1, 2'd1, 4'd2, 8'd0, 8'd0);
    hit_b = 1'b1; repeat (3) step();
    miss_b = 1'b1; step(); hit_b = 1'b0; miss_b = 1'b0;
    expect_st("b_hit_miss", 1, 2'd2, 4'd1, 8'd4, 8'd0);
    step();                          expect_st("b_wait0_play", 1, 2'd1, 4'd1, 8'd4, 8'd0);
    hit_b = 1'b1; repeat (9) step(); hit_b = 1'b0;
    expect_st("b_saturate", 1, 2'd1, 4'd1, 8'd7, 8'd0);
    miss_b = 1'b1; step(); miss_b = 1'b0;
    step();                          expect_st("b_last_ball", 1, 2'd1, 4'd0, 8'd7, 8'd0);
    miss_b = 1'b1; step(); miss_b = 1'b0;
    expect_st("b_over", 1, 2'd3, 4'd0, 8'd7, 8'd7);
    step();                          expect_st("b_newgame", 1, 2'd0, 4'd3, 8'd7, 8'd7);

    step(); step();
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
